// File: rtl/nios_cpu_oci_dct_packer.sv
// rtl/nios_cpu_oci_dct_packer.sv - packs OCI trace fragments into dct_buffer words
//
// Purpose: accumulates FRAG_W-bit trace fragments into NUM_FRAGS-fragment words,
// presents them on a valid/ready output, sequences the end-of-test drain and
// flags dropped fragments. The trace source cannot be stalled.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   frag_valid/data   incoming trace fragment (no backpressure)
//   flush             pulse: emit the current partial word
//   test_ending       level or pulse: start the end-of-test drain
//   dct_buffer/count  output word and its fragment count (1..NUM_FRAGS)
//   dct_valid/ready   output handshake
//   overflow          sticky: a fragment was dropped
//   test_has_ended    sticky: drain complete
//   stat_words/drops  dequeue and drop counters, saturating
//                     (present only when DCT_PACKER_STATS_EN is defined)
module nios_cpu_oci_dct_packer #(
    parameter int FRAG_W    = 2,
    parameter int NUM_FRAGS = 15,
    parameter int CNT_W     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frag_valid,
    input  logic [FRAG_W-1:0]           frag_data,
    input  logic                        flush,
    input  logic                        test_ending,
    output logic [FRAG_W*NUM_FRAGS-1:0] dct_buffer,
    output logic [CNT_W-1:0]            dct_count,
    output logic                        dct_valid,
    input  logic                        dct_ready,
    output logic                        overflow,
    output logic                        test_has_ended
`ifdef DCT_PACKER_STATS_EN
    ,
    output logic [15:0]                 stat_words,
    output logic [15:0]                 stat_drops
`endif
);

    localparam int ACC_W = FRAG_W * NUM_FRAGS;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_FRAGS);

    logic [ACC_W-1:0] acc, acc_nxt, frag_word;
    logic [CNT_W-1:0] acc_cnt, cnt_nxt;
    logic             flush_pend, fp_nxt;
    logic             end_latch;
    logic             slot_free, full, xfer, drop, accept, flush_req, dequeue;

    always_comb begin
        slot_free = !dct_valid || dct_ready;
        full      = (acc_cnt == FULL);
        xfer      = slot_free && (full || (flush_pend && (acc_cnt != '0)));
        // Once the drain has started, fragments are ignored rather than dropped.
        drop      = frag_valid && !end_latch && full && !slot_free;
        accept    = frag_valid && !end_latch && !drop;
        flush_req = flush || (test_ending && !end_latch);
        dequeue   = dct_valid && dct_ready;
        frag_word = ACC_W'(frag_data);

        acc_nxt = acc;
        cnt_nxt = acc_cnt;
        if (xfer) begin
            // A fragment arriving with the transfer starts the fresh word.
            acc_nxt = accept ? frag_word : '0;
            cnt_nxt = accept ? CNT_W'(1) : '0;
        end else if (accept) begin
            acc_nxt = acc | (frag_word << (acc_cnt * FRAG_W));
            cnt_nxt = acc_cnt + CNT_W'(1);
        end

        // A flush only arms when something will be left to emit; a flush that
        // coincides with a full-word transfer applies to the new contents.
        fp_nxt = (flush_pend && !xfer) || (flush_req && (cnt_nxt != '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc            <= '0;
            acc_cnt        <= '0;
            flush_pend     <= 1'b0;
            end_latch      <= 1'b0;
            dct_buffer     <= '0;
            dct_count      <= '0;
            dct_valid      <= 1'b0;
            overflow       <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            acc        <= acc_nxt;
            acc_cnt    <= cnt_nxt;
            flush_pend <= fp_nxt;
            if (test_ending)
                end_latch <= 1'b1;
            if (xfer) begin
                dct_buffer <= acc;
                dct_count  <= acc_cnt;
                dct_valid  <= 1'b1;
            end else if (dequeue) begin
                dct_valid  <= 1'b0;
            end
            if (drop)
                overflow <= 1'b1;
            if (end_latch && (acc_cnt == '0) && !flush_pend && !dct_valid)
                test_has_ended <= 1'b1;
        end
    end

`ifdef DCT_PACKER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_words <= '0;
            stat_drops <= '0;
        end else begin
            if (dequeue && (stat_words != 16'hFFFF))
                stat_words <= stat_words + 16'd1;
            if (drop && (stat_drops != 16'hFFFF))
                stat_drops <= stat_drops + 16'd1;
        end
    end
`endif

endmodule
